// File: rtl/fifo_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_flow_ctrl
// Brief   : Synchronous FIFO of {valid, data} entries with registered read
//           port, sticky overflow/underflow errors, programmable almost-full
//           and almost-empty levels, and hysteresis flow control
//           (pause / continua).
// Revision: 1.0 - initial release
// ============================================================================
module fifo_flow_ctrl #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  valid,
  input  logic [BUS_SIZE-1:0]   data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   filled,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pause,
  output logic                  continua,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  fifo_error,
  output logic                  cfg_err
);

  // Entry count as an occupancy value, and as an array size.
  localparam logic [ADDR_WIDTH:0] c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int                  c_DEPTH_N = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_FLOW  = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  // Each entry carries the valid tag in its MSB.
  logic [BUS_SIZE:0]     r_mem [c_DEPTH_N];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_filled;
  logic [BUS_SIZE-1:0]   r_data_out;
  logic                  r_valid_out;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_continua;
  state_t                r_state;
  state_t                w_state_next;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;
  logic [ADDR_WIDTH:0]   w_filled_next;

  assign w_empty = (r_filled == '0);
  assign w_full  = (r_filled == c_DEPTH);

  // Flush swallows both requests, so neither can be accepted nor flag an error.
  assign w_pop_ok  = pop  && !w_empty && !flush;
  assign w_push_ok = push && (!w_full || w_pop_ok) && !flush;
  assign w_ovf_evt = push && w_full && !w_pop_ok && !flush;
  assign w_unf_evt = pop  && w_empty && !flush;

  // Post-update occupancy; also drives the flow-control decision.
  always_comb begin
    w_filled_next = r_filled;
    if (flush) begin
      w_filled_next = '0;
    end else begin
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   w_filled_next = r_filled + (ADDR_WIDTH+1)'(1);
        2'b01:   w_filled_next = r_filled - (ADDR_WIDTH+1)'(1);
        default: w_filled_next = r_filled;
      endcase
    end
  end

  // Storage array: written on accepted push only, never reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {valid, data_in};
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_filled <= '0;
    end else begin
      r_filled <= w_filled_next;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered read port; data holds between pops, the strobe does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (w_pop_ok) begin
      r_data_out  <= r_mem[r_rd_ptr][BUS_SIZE-1:0];
      r_valid_out <= r_mem[r_rd_ptr][BUS_SIZE];
    end else begin
      r_valid_out <= 1'b0;
    end
  end

  // Sticky errors; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)      r_overflow  <= 1'b1;
      else if (clear_err) r_overflow  <= 1'b0;
      if (w_unf_evt)      r_underflow <= 1'b1;
      else if (clear_err) r_underflow <= 1'b0;
    end
  end

  // Flow-control state register plus one-cycle resume pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FLOW;
      r_continua <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_continua <= (r_state == ST_PAUSE) && (w_state_next == ST_FLOW);
    end
  end

  // Hysteresis next-state: pause at the high mark, resume at the low mark.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_FLOW;
    end else begin
      unique case (r_state)
        ST_FLOW:  if (w_filled_next >= umbral_alto) w_state_next = ST_PAUSE;
        ST_PAUSE: if (w_filled_next <= umbral_bajo) w_state_next = ST_FLOW;
        default:  w_state_next = ST_FLOW;
      endcase
    end
  end

  assign data_out      = r_data_out;
  assign valid_out     = r_valid_out;
  assign filled        = r_filled;
  assign empty         = w_empty;
  assign full          = w_full;
  assign almost_full   = (r_filled >= umbral_alto);
  assign almost_empty  = (r_filled <= umbral_bajo);
  assign pause         = (r_state == ST_PAUSE);
  assign continua      = r_continua;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;
  assign fifo_error    = r_overflow | r_underflow;
  assign cfg_err       = (umbral_bajo >= umbral_alto) || (umbral_alto > c_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_fifo_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_flow_ctrl
// Brief   : Self-checking bench for fifo_flow_ctrl (BUS_SIZE=5, ADDR_WIDTH=3)
//           with a behavioural FIFO model and a read-data scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, valid, flush, clear_err;
  logic [4:0] data_in;
  logic [3:0] umbral_alto, umbral_bajo;
  logic [4:0] data_out;
  logic       valid_out;
  logic [3:0] filled;
  logic       empty, full, almost_full, almost_empty, pause, continua;
  logic       overflow_err, underflow_err, fifo_error, cfg_err;

  int alto = 6;
  int bajo = 2;
  assign umbral_alto = 4'(alto);
  assign umbral_bajo = 4'(bajo);

  fifo_flow_ctrl #(.BUS_SIZE(5), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(rst_n), .push(push), .pop(pop), .valid(valid),
    .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .flush(flush), .clear_err(clear_err), .data_out(data_out),
    .valid_out(valid_out), .filled(filled), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .pause(pause),
    .continua(continua), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .fifo_error(fifo_error), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: FIFO contents and scoreboard of expected read results.
  logic [5:0] mq[$];
  logic [5:0] sb[$];
  logic [4:0] m_data_out = '0;
  logic       m_ovf = 0, m_unf = 0, m_pause = 0, m_cont = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int nf = mq.size();
    check_val("filled",        32'(filled),        32'(nf));
    check_val("empty",         32'(empty),         32'(nf == 0));
    check_val("full",          32'(full),          32'(nf == 8));
    check_val("almost_full",   32'(almost_full),   32'(nf >= alto));
    check_val("almost_empty",  32'(almost_empty),  32'(nf <= bajo));
    check_val("pause",         32'(pause),         32'(m_pause));
    check_val("continua",      32'(continua),      32'(m_cont));
    check_val("overflow_err",  32'(overflow_err),  32'(m_ovf));
    check_val("underflow_err", 32'(underflow_err), 32'(m_unf));
    check_val("fifo_error",    32'(fifo_error),    32'(m_ovf | m_unf));
  endtask

  // One clock cycle: drive inputs, advance the model, then compare.
  task automatic cycle(input logic p, input logic q, input logic v,
                       input logic [4:0] d, input logic fl, input logic ce);
    int         sz = mq.size();
    logic       pop_ok, push_ok, old_pause;
    logic [5:0] e;
    pop_ok  = q && (sz > 0) && !fl;
    push_ok = p && (sz < 8 || pop_ok) && !fl;
    if (ce) begin m_ovf = 0; m_unf = 0; end
    if (p && !fl && sz == 8 && !pop_ok) m_ovf = 1;
    if (q && !fl && sz == 0) m_unf = 1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_ok)  sb.push_back(mq.pop_front());
      if (push_ok) mq.push_back({v, d});
    end
    old_pause = m_pause;
    if (fl)                           m_pause = 0;
    else if (!m_pause && mq.size() >= alto) m_pause = 1;
    else if (m_pause && mq.size() <= bajo)  m_pause = 0;
    m_cont = old_pause && !m_pause;

    push = p; pop = q; valid = v; data_in = d; flush = fl; clear_err = ce;
    @(posedge clk);
    #1;
    if (pop_ok) begin
      e = sb.pop_front();
      m_data_out = e[4:0];
      check_val("rd_data",  32'(data_out),  32'(e[4:0]));
      check_val("rd_valid", 32'(valid_out), 32'(e[5]));
    end else begin
      check_val("idle_valid", 32'(valid_out), 32'(0));
      check_val("hold_data",  32'(data_out),  32'(m_data_out));
    end
    check_all();
    push = 0; pop = 0; flush = 0; clear_err = 0;
  endtask

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_data_out = '0; m_ovf = 0; m_unf = 0; m_pause = 0; m_cont = 0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_data_out",  32'(data_out),  32'(0));
    check_val("rst_valid_out", 32'(valid_out), 32'(0));
    check_all();
  endtask

  initial begin
    rst_n = 0; push = 0; pop = 0; valid = 0; data_in = '0; flush = 0; clear_err = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_reset_outputs();
    check_val("cfg_ok", 32'(cfg_err), 32'(0));
    @(negedge clk) rst_n = 1;

    // Fill 1..8, then overflow on the ninth push.
    for (int i = 1; i <= 8; i++) cycle(1, 0, 1, 5'(i), 0, 0);
    cycle(1, 0, 1, 5'd9, 0, 0);
    // Drain 1..8, then underflow on the ninth pop.
    for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 5'd0, 0, 0);
    cycle(0, 1, 0, 5'd0, 0, 0);

    // Clear, then clear racing a new underflow (error must stay), then clear.
    cycle(0, 0, 0, 5'd0, 0, 1);
    cycle(0, 1, 0, 5'd0, 0, 1);
    cycle(0, 0, 0, 5'd0, 0, 1);

    // Wrap: pointers pass 7 -> 0 with order preserved.
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 5'(10 + i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 5'd0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 5'(16 + i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 5'd0, 0, 0);

    // Simultaneous push+pop when full (mixed tags), then when empty.
    for (int i = 0; i < 8; i++) cycle(1, 0, 1'(i), 5'(20 + i), 0, 0);
    cycle(1, 1, 1, 5'd30, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 5'd0, 0, 0);
    cycle(1, 1, 1, 5'd7, 0, 0);
    cycle(0, 1, 0, 5'd0, 0, 1);

    // Flush at filled=4 with an error pending; requests ignored, error kept.
    cycle(0, 1, 0, 5'd0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 5'(3 + i), 0, 0);
    cycle(1, 1, 1, 5'd31, 1, 0);
    cycle(1, 0, 1, 5'd12, 0, 0);
    cycle(0, 1, 0, 5'd0, 0, 0);

    // Asynchronous reset mid-burst at filled=5.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 5'(i), 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk) rst_n = 1;
    cycle(1, 0, 1, 5'd17, 0, 0);
    cycle(0, 1, 0, 5'd0, 0, 0);

    // Threshold configuration errors.
    alto = 6; bajo = 7; #1;
    check_val("cfg_bajo_ge_alto", 32'(cfg_err), 32'(1));
    alto = 9; bajo = 2; #1;
    check_val("cfg_alto_gt_depth", 32'(cfg_err), 32'(1));
    alto = 8; bajo = 7; #1;
    check_val("cfg_edge_ok", 32'(cfg_err), 32'(0));
    alto = 6; bajo = 2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_flow_ctrl.md
FIFO_FLOW_CTRL -- requirements
Module: fifo_flow_ctrl

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 5, data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2^ADDR_WIDTH entries, all usable.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset, takes effect without clk).
REQ-005 SHALL have ports push / pop, input, 1 each, write / read request.
REQ-006 SHALL have port valid, input, 1, valid tag stored alongside data_in.
REQ-007 SHALL have port data_in, input, BUS_SIZE, write data.
REQ-008 SHALL have ports umbral_alto / umbral_bajo, input, ADDR_WIDTH+1 each, pause / resume thresholds.
REQ-009 SHALL have ports flush / clear_err, input, 1 each, synchronous flush / sticky-error clear.
REQ-010 SHALL have port data_out, output, BUS_SIZE, registered read data.
REQ-011 SHALL have port valid_out, output, 1, registered read strobe (tag of popped entry).
REQ-012 SHALL have port filled, output, ADDR_WIDTH+1, occupancy 0..DEPTH.
REQ-013 SHALL have ports empty, full, almost_full, almost_empty, output, 1 each, status flags.
REQ-014 SHALL have ports pause / continua, output, 1 each, flow-control level / resume pulse.
REQ-015 SHALL have ports overflow_err, underflow_err, fifo_error, cfg_err, output, 1 each, error flags.

Function
REQ-016 SHALL store DEPTH entries of {valid, data}; wr_ptr/rd_ptr ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally.
REQ-017 SHALL keep filled as a registered counter: +1 accepted push only, -1 accepted pop only, unchanged when both or neither.
REQ-018 SHALL decode empty = (filled==0), full = (filled==DEPTH), combinationally.
REQ-019 SHALL accept push iff !full, or full with pop accepted same cycle; rejected push writes nothing, moves no pointer.
REQ-020 SHALL accept pop iff !empty; push+pop on empty: push accepted, pop rejected.
REQ-021 SHALL, on accepted pop at edge N, drive data_out = mem[rd_ptr], valid_out = stored tag, both visible after edge N (1-cycle latency).
REQ-022 SHALL drive valid_out = 0 in any cycle following no accepted pop; data_out holds last value.
REQ-023 SHALL set overflow_err (sticky) on push rejected due to full; underflow_err (sticky) on pop with empty.
REQ-024 SHALL clear both sticky errors on clear_err=1 at edge; a new error in the same cycle wins (stays set).
REQ-025 SHALL drive fifo_error = overflow_err | underflow_err.
REQ-026 SHALL drive cfg_err = (umbral_bajo >= umbral_alto) | (umbral_alto > DEPTH), combinationally.
REQ-027 SHALL drive almost_full = (filled >= umbral_alto), almost_empty = (filled <= umbral_bajo), combinationally.
REQ-028 SHALL implement 2-state FSM FLOW/PAUSE evaluated on post-update occupancy (filled_next).
REQ-029 SHALL transition FLOW -> PAUSE when filled_next >= umbral_alto; PAUSE -> FLOW when filled_next <= umbral_bajo; otherwise hold (hysteresis).
REQ-030 SHALL drive pause = 1 in PAUSE; continua = 1 for exactly one cycle after each PAUSE -> FLOW transition.
REQ-031 SHALL, on flush=1, zero pointers and filled, set valid_out=0, FSM to FLOW, ignore push/pop that cycle; errors and data_out unchanged.
REQ-032 SHALL give flush priority over push/pop and clear_err independent of flush.

Reset
REQ-033 SHALL, while reset=0, force wr_ptr=rd_ptr=0, filled=0, data_out=0, valid_out=0, errors=0, FSM=FLOW, continua=0.
REQ-034 SHALL, mid-operation reset, discard all contents; memory array need not be cleared.
REQ-035 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Verification (BUS_SIZE=5, ADDR_WIDTH=3)
REQ-036 Fill: 8 pushes data 1..8 valid=1 -> filled=8, full=1, no error; 9th push -> overflow_err=1, filled=8.
REQ-037 Drain: 8 pops after fill -> data_out 1..8 one cycle after each pop, valid_out=1 each; 9th pop -> underflow_err=1, valid_out=0.
REQ-038 Wrap: 6 push, 6 pop, 6 push, 6 pop with data 0x0A..0x15 -> order preserved, pointers pass 7 -> 0, filled returns 0.
REQ-039 Hysteresis: umbral_alto=6, umbral_bajo=2 -> pause rises after 6th push; pops to filled=2 -> pause falls, continua one-cycle pulse.
REQ-040 Simultaneous: full FIFO, push+pop same cycle -> filled stays 8, no overflow; empty FIFO, push+pop -> filled=1, underflow_err=1.
REQ-041 Reset/flush: assert reset=0 mid-burst at filled=5 -> all outputs to reset values immediately; flush at filled=4 -> filled=0, errors retained.
